// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-wide slice walks a WIDTH-bit operand pair
// least significant digit first, with carry held in a register between digits.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             SUB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             C4,
    output logic             OV
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] f_q;
    logic             c4_q;
    logic             ov_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [DIGIT:0]   slice_d;
    logic             last_d;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic f_msb);
        return (a_msb == b_msb) && (f_msb != a_msb);
    endfunction

    // Slice stage: low digit of each operand plus carry; sum enters the result from the top
    always_comb begin
        slice_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        res_d   = (res_q >> DIGIT) | (WIDTH'(slice_d[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CNT_W'(1);
        last_d  = (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            f_q     <= '0;
            c4_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        carry_q <= SUB ? ~C0 : C0;
                    end
                end
                RUN: begin
                    carry_q <= slice_d[DIGIT];
                    cnt_q   <= cnt_d;
                    if (last_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        f_q     <= res_d;
                        c4_q    <= slice_d[DIGIT];
                        ov_q    <= signed_ovf(a_msb_q, b_msb_q, res_d[WIDTH-1]);
                    end
                end
            endcase
        end
    end

    // Operand stage: subtraction is folded in as A + ~B + ~C0 when the operands are captured
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= SUB ? ~B[WIDTH-1] : B[WIDTH-1];
            res_q   <= '0;
        end else if (state_q == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            res_q <= res_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign F    = f_q;
    assign C4   = c4_q;
    assign OV   = ov_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: a 16/4 instance and an 8/8 instance
// checked against an integer-arithmetic reference model.
module tb_digit_serial_adder;

    localparam int N0 = 4;
    localparam int N1 = 1;

    typedef struct {
        logic [31:0] f;
        logic        c4;
        logic        ov;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, c0_0, sub0, busy0, done0, c4_0, ov0;
    logic [15:0] a0, b0, f0;
    logic        start1, c0_1, sub1, busy1, done1, c4_1, ov1;
    logic [7:0]  a1, b1, f1;

    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   hold0, hold1, e;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     rem0 = 0;
    int     rem1 = 0;
    logic   rst_edge = 1'b0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .C0(c0_0), .SUB(sub0),
        .busy(busy0), .done(done0), .F(f0), .C4(c4_0), .OV(ov0)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .C0(c0_1), .SUB(sub1),
        .busy(busy1), .done(done1), .F(f1), .C4(c4_1), .OV(ov1)
    );

    function automatic exp_t ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic c0, input logic sub, input longint due);
        exp_t   r;
        longint full, half, ua, ub, sa, sb, u, s;
        full = longint'(1) << w;
        half = full >> 1;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        if (sub) begin
            u    = ua - ub - longint'(c0);
            s    = sa - sb - longint'(c0);
            r.c4 = (ua >= ub + longint'(c0));
        end else begin
            u    = ua + ub + longint'(c0);
            s    = sa + sb + longint'(c0);
            r.c4 = (u >= full);
        end
        r.f   = 32'(u & (full - 1));
        r.ov  = (s >= half) || (s < -half);
        r.cyc = due;
        return r;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] r;
        logic [31:0] mask;
        mask = 32'((longint'(1) << w) - 1);
        r    = $urandom;
        case ($urandom_range(0, 7))
            0: r = 32'h0;
            1: r = mask;
            2: r = mask >> 1;
            3: r = 32'(1) << (w - 1);
            default: ;
        endcase
        return r & mask;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run0(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        a0 = a; b0 = b; c0_0 = c; sub0 = s; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < N0; i++) begin
            a0 = 16'($urandom); b0 = 16'($urandom); c0_0 = 1'($urandom); sub0 = 1'($urandom);
            tick();
        end
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        a1 = a; b1 = b; c0_1 = c; sub1 = s; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom);
        tick();
    endtask

    // Acceptance model: an operation is taken when start is seen with nothing outstanding
    initial forever begin
        @(posedge clk);
        cyc++;
        rst_edge = rst;
        if (rst) begin
            rem0 = 0;
            rem1 = 0;
        end else begin
            if (rem0 == 0 && start0) begin
                q0.push_back(ref_op(16, 32'(a0), 32'(b0), c0_0, sub0, cyc + N0));
                rem0 = N0;
            end else if (rem0 > 0) begin
                rem0--;
            end
            if (rem1 == 0 && start1) begin
                q1.push_back(ref_op(8, 32'(a1), 32'(b1), c0_1, sub1, cyc + N1));
                rem1 = N1;
            end else if (rem1 > 0) begin
                rem1--;
            end
        end
    end

    // Monitor: pops an expectation whenever a DUT reports done
    initial forever begin
        @(negedge clk);
        if (rst_edge) begin
            q0.delete();
            q1.delete();
            hold0 = '{f: 32'h0, c4: 1'b0, ov: 1'b0, cyc: 0};
            hold1 = '{f: 32'h0, c4: 1'b0, ov: 1'b0, cyc: 0};
        end
        chk("busy0", 32'(busy0), 32'(rem0 != 0));
        chk("busy1", 32'(busy1), 32'(rem1 != 0));
        if (done0) begin
            chk("done_busy0", 32'(busy0), 32'h0);
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL done0_unexpected: done=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                e = q0.pop_front();
                chk("latency0", 32'(cyc), 32'(e.cyc));
                hold0 = e;
            end
        end
        if (done1) begin
            chk("done_busy1", 32'(busy1), 32'h0);
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL done1_unexpected: done=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                e = q1.pop_front();
                chk("latency1", 32'(cyc), 32'(e.cyc));
                hold1 = e;
            end
        end
        chk("F0", 32'(f0), hold0.f);
        chk("C4_0", 32'(c4_0), 32'(hold0.c4));
        chk("OV0", 32'(ov0), 32'(hold0.ov));
        chk("F1", 32'(f1), hold1.f);
        chk("C4_1", 32'(c4_1), 32'(hold1.c4));
        chk("OV1", 32'(ov1), 32'(hold1.ov));
    end

    initial begin
        rst = 1'b1;
        start0 = 1'b1; a0 = 16'hFFFF; b0 = 16'h0001; c0_0 = 1'b0; sub0 = 1'b0;
        start1 = 1'b1; a1 = 8'hFF;    b1 = 8'h01;    c0_1 = 1'b0; sub1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        tick();

        run0(16'h1234, 16'h4321, 1'b1, 1'b0);
        run0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run0(16'h0005, 16'h0007, 1'b0, 1'b1);
        run0(16'h8000, 16'h0001, 1'b0, 1'b1);

        // Start while busy is dropped, start on the done cycle is taken, reset abandons the op
        a0 = 16'h0001; b0 = 16'h0001; c0_0 = 1'b0; sub0 = 1'b0; start0 = 1'b1;
        tick();
        a0 = 16'h1111; b0 = 16'h2222;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        a0 = 16'h00FF; b0 = 16'h0F00; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();

        run1(8'hF0, 8'h20, 1'b0, 1'b0);
        run1(8'h7F, 8'h01, 1'b0, 1'b0);
        run1(8'h80, 8'h01, 1'b1, 1'b1);

        for (int i = 0; i < 7000; i++) begin
            a0 = 16'(pick(16)); b0 = 16'(pick(16));
            c0_0 = 1'($urandom); sub0 = 1'($urandom);
            start0 = ($urandom_range(0, 3) != 0);
            a1 = 8'(pick(8)); b1 = 8'(pick(8));
            c0_1 = 1'($urandom); sub1 = 1'($urandom);
            start1 = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;

        for (int i = 0; i < 20 && (rem0 != 0 || rem1 != 0); i++) tick();
        tick(); tick();
        chk("pending0", 32'(q0.size()), 32'h0);
        chk("pending1", 32'(q1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
